// File: rtl/bram_arbiter.sv
// Two-requester arbiter for the shared single-port BRAM: round-robin on ties,
// requester 1 burst lock, and a per-requester starvation guard.
module bram_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic                  i_write0,
    input  logic                  i_write1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    input  logic                  i_lock1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic                  o_bram_write,
    output logic [DATA_WIDTH-1:0] o_bram_data,
    input  logic [DATA_WIDTH-1:0] i_bram_data
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic       last_q, last_d;
    logic       lock_q, lock_d;
    logic [3:0] wait0_q, wait0_d;
    logic [3:0] wait1_q, wait1_d;
    logic       rvalid0_q, rvalid1_q;
    logic       starve0, starve1;
    logic       gnt0, gnt1;

    always_comb begin
        starve0 = i_req0 && (wait0_q == MaxWait);
        starve1 = i_req1 && (wait1_q == MaxWait);
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        if (!i_rst) begin
            // last_q names the previous winner, so the other side takes any tie
            if (starve0 && starve1) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else if (starve0) begin
                gnt0 = 1'b1;
            end else if (starve1) begin
                gnt1 = 1'b1;
            end else if (lock_q && i_req1) begin
                gnt1 = 1'b1;
            end else if (i_req0 && i_req1) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = i_req0;
                gnt1 = i_req1;
            end
        end
    end

    always_comb begin
        o_bram_addr  = '0;
        o_bram_write = 1'b0;
        o_bram_data  = '0;
        if (gnt0) begin
            o_bram_addr  = i_addr0;
            o_bram_write = i_write0;
            o_bram_data  = i_wdata0;
        end else if (gnt1) begin
            o_bram_addr  = i_addr1;
            o_bram_write = i_write1;
            o_bram_data  = i_wdata1;
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end

        // A starvation-forced grant to requester 0 breaks the lock for good
        lock_d = lock_q;
        if (gnt0 && starve0) begin
            lock_d = 1'b0;
        end else if (!i_lock1) begin
            lock_d = 1'b0;
        end else if (gnt1) begin
            lock_d = 1'b1;
        end

        wait0_d = '0;
        if (i_req0 && !gnt0) begin
            wait0_d = (wait0_q == MaxWait) ? wait0_q : wait0_q + 4'd1;
        end
        wait1_d = '0;
        if (i_req1 && !gnt1) begin
            wait1_d = (wait1_q == MaxWait) ? wait1_q : wait1_q + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q    <= 1'b1;
            lock_q    <= 1'b0;
            wait0_q   <= '0;
            wait1_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            lock_q    <= lock_d;
            wait0_q   <= wait0_d;
            wait1_q   <= wait1_d;
            rvalid0_q <= gnt0 && !i_write0;
            rvalid1_q <= gnt1 && !i_write1;
        end
    end

    assign o_gnt0    = gnt0;
    assign o_gnt1    = gnt1;
    assign o_rvalid0 = rvalid0_q;
    assign o_rvalid1 = rvalid1_q;
    assign o_rdata   = i_bram_data;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios plus random traffic, all checked
// against a rule-level model of the arbiter and a behavioural BRAM.
module tb_bram_arbiter;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int MW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req0, req1, write0, write1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata, bram_wdata, bram_rdata;
    logic [AW-1:0] bram_addr;
    logic          bram_write;

    bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_req1(req1),
        .i_addr0(addr0), .i_addr1(addr1),
        .i_write0(write0), .i_write1(write1),
        .i_wdata0(wdata0), .i_wdata1(wdata1),
        .i_lock1(lock1),
        .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata(rdata),
        .o_bram_addr(bram_addr), .o_bram_write(bram_write), .o_bram_data(bram_wdata),
        .i_bram_data(bram_rdata)
    );

    // Behavioural single-port BRAM, read-first, one cycle read latency
    logic [DW-1:0] mem [1<<AW];
    always @(posedge clk) begin
        bram_rdata <= mem[bram_addr];
        if (bram_write) mem[bram_addr] = bram_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [1<<AW];
    int            m_last, m_lock, m_g;
    int            m_w [2];
    bit            m_rv [2];
    logic [DW-1:0] m_exp;
    bit            m_known = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input bit r0, input int a0, input bit w0, input int d0,
                          input bit r1, input int a1, input bit w1, input int d1, input bit lk);
        req0 = r0; addr0 = AW'(a0); write0 = w0; wdata0 = DW'(d0);
        req1 = r1; addr1 = AW'(a1); write1 = w1; wdata1 = DW'(d1);
        lock1 = lk;
    endtask

    // Predict, compare, advance the model, then move to 1 time unit past the next edge
    task automatic cycle();
        bit s0, s1;
        bit rq [2];
        #1;
        rq[0] = req0;
        rq[1] = req1;
        s0 = req0 && (m_w[0] == MW);
        s1 = req1 && (m_w[1] == MW);
        if (rst)                        m_g = -1;
        else if (s0 && s1)              m_g = 1 - m_last;
        else if (s0)                    m_g = 0;
        else if (s1)                    m_g = 1;
        else if (m_lock == 1 && req1)   m_g = 1;
        else if (req0 && req1)          m_g = 1 - m_last;
        else if (req0)                  m_g = 0;
        else if (req1)                  m_g = 1;
        else                            m_g = -1;

        check_eq("gnt0", 32'(gnt0), 32'(m_g == 0));
        check_eq("gnt1", 32'(gnt1), 32'(m_g == 1));
        check_eq("bram_addr", 32'(bram_addr), m_g == 0 ? 32'(addr0) : m_g == 1 ? 32'(addr1) : 0);
        check_eq("bram_write", 32'(bram_write),
                 m_g == 0 ? 32'(write0) : m_g == 1 ? 32'(write1) : 0);
        check_eq("bram_data", 32'(bram_wdata),
                 m_g == 0 ? 32'(wdata0) : m_g == 1 ? 32'(wdata1) : 0);
        if (m_known) begin
            check_eq("rvalid0", 32'(rvalid0), 32'(m_rv[0]));
            check_eq("rvalid1", 32'(rvalid1), 32'(m_rv[1]));
            if (m_rv[0] || m_rv[1]) check_eq("rdata", 32'(rdata), 32'(m_exp));
        end

        if (rst) begin
            m_last = 1; m_lock = 0; m_w[0] = 0; m_w[1] = 0;
            m_rv[0] = 0; m_rv[1] = 0; m_known = 1'b1;
        end else begin
            if (m_g == 0 && s0)      m_lock = 0;
            else if (!lock1)         m_lock = 0;
            else if (m_g == 1)       m_lock = 1;
            for (int n = 0; n < 2; n++) begin
                if (rq[n] && m_g != n) m_w[n] = (m_w[n] < MW) ? m_w[n] + 1 : MW;
                else                   m_w[n] = 0;
            end
            m_rv[0] = (m_g == 0) && !write0;
            m_rv[1] = (m_g == 1) && !write1;
            if (m_g == 0) begin
                m_last = 0;
                m_exp  = ref_mem[addr0];
                if (write0) ref_mem[addr0] = wdata0;
            end else if (m_g == 1) begin
                m_last = 1;
                m_exp  = ref_mem[addr1];
                if (write1) ref_mem[addr1] = wdata1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    bit            pend [2];
    logic [AW-1:0] pa [2];
    bit            pw [2];
    logic [DW-1:0] pd [2];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = DW'(i * 3 + 1);
            ref_mem[i] = DW'(i * 3 + 1);
        end
        mem[5]     = 8'hA5;
        ref_mem[5] = 8'hA5;
        m_last = 1; m_lock = 0; m_g = -1; m_w[0] = 0; m_w[1] = 0;
        m_rv[0] = 0; m_rv[1] = 0; m_exp = '0;

        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        cycle();
        cycle();

        // Uncontended read, zero-latency grant, data next cycle
        rst = 1'b0;
        set_in(1, 5, 0, 0, 0, 0, 0, 0, 0);
        #1 check_eq("t1_gnt0", 32'(gnt0), 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t1_rvalid0", 32'(rvalid0), 1);
        check_eq("t1_rdata", 32'(rdata), 32'hA5);
        cycle();

        // Continuous contention alternates, starting with requester 0
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_in(1, 1, 0, 0, 1, 2, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq("t2_gnt0", 32'(gnt0), 32'(i % 2 == 0));
            check_eq("t2_gnt1", 32'(gnt1), 32'(i % 2 == 1));
            cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Same-address read/write tie: read sees old data, later read sees new
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_in(1, 7, 0, 0, 1, 7, 1, 8'h3C, 0);
        #1 check_eq("t3_gnt0", 32'(gnt0), 1);
        cycle();
        set_in(0, 0, 0, 0, 1, 7, 1, 8'h3C, 0);
        check_eq("t3_old_rvalid", 32'(rvalid0), 1);
        check_eq("t3_old_rdata", 32'(rdata), 32'h16);
        #1 check_eq("t3_gnt1", 32'(gnt1), 1);
        cycle();
        set_in(1, 7, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t3_new_rdata", 32'(rdata), 32'h3C);
        cycle();

        // Lock held by requester 1; requester 0 forced through after MAX_WAIT
        set_in(1, 3, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 4, 0, 0, 1, 9, 1, 8'h77, 1);
            #1;
            check_eq("t4_gnt1", 32'(gnt1), 32'(i < 4));
            check_eq("t4_gnt0", 32'(gnt0), 32'(i == 4));
            cycle();
        end
        set_in(0, 0, 0, 0, 1, 9, 1, 8'h77, 1);
        #1 check_eq("t4_reacquire", 32'(gnt1), 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Reset with a read in flight
        set_in(1, 5, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        rst = 1'b1;
        set_in(1, 2, 0, 0, 1, 3, 0, 0, 0);
        #1;
        check_eq("t5_rst_gnt", 32'({gnt0, gnt1}), 0);
        check_eq("t5_rst_rvalid", 32'(rvalid0), 1);
        check_eq("t5_rst_rdata", 32'(rdata), 32'hA5);
        cycle();
        rst = 1'b0;
        #1;
        check_eq("t5_post_rvalid", 32'(rvalid0), 0);
        check_eq("t5_post_tie", 32'(gnt0), 1);
        cycle();

        // Requester 0 denied once, then drops its request
        set_in(1, 6, 0, 0, 1, 3, 0, 0, 0);
        #1 check_eq("t6_denied", 32'(gnt0), 0);
        cycle();
        set_in(0, 6, 0, 0, 1, 8, 0, 0, 0);
        #1 check_eq("t6_drop", 32'(bram_addr), 8);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Random traffic honouring the hold-until-grant protocol
        pend[0] = 0;
        pend[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n]) begin
                    if ($urandom_range(3) != 0) begin
                        pend[n] = 1;
                        pa[n]   = AW'($urandom_range(15));
                        pw[n]   = 1'($urandom_range(1));
                        pd[n]   = DW'($urandom);
                    end
                end else if ($urandom_range(15) == 0) begin
                    pend[n] = 0;
                end
            end
            if ($urandom_range(7) == 0) lock1 = ~lock1;
            rst = ($urandom_range(99) == 0);
            req0 = pend[0]; addr0 = pa[0]; write0 = pw[0]; wdata0 = pd[0];
            req1 = pend[1]; addr1 = pa[1]; write1 = pw[1]; wdata1 = pd[1];
            cycle();
            if (m_g == 0) pend[0] = 0;
            if (m_g == 1) pend[1] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-requester arbiter that shares the single-port BRAM between the CPU memory path (requester 0) and a secondary master such as a UART loader or DMA engine (requester 1). It issues at most one BRAM access per cycle and resolves conflicts round-robin. Requester 1 can lock the port for bursts, and a starvation guard bounds how long either side waits. It sits between the memory map's BRAM interface and the `bram` instance, with the BRAM port widths unchanged.

## Interface
- `DATA_WIDTH`, default 8: BRAM word width.
- `ADDR_WIDTH`, default 10: BRAM address width.
- `MAX_WAIT`, default 4: consecutive denied cycles after which a requester is forced through. Range 1..15.
- `i_clk`, in, 1: single clock, rising edge.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_req0` / `i_req1`, in, 1 each: access request.
- `i_addr0` / `i_addr1`, in, `ADDR_WIDTH` each: word address.
- `i_write0` / `i_write1`, in, 1 each: 1 = write, 0 = read.
- `i_wdata0` / `i_wdata1`, in, `DATA_WIDTH` each: write data.
- `i_lock1`, in, 1: requester 1 keeps ownership while this is high.
- `o_gnt0` / `o_gnt1`, out, 1 each: access issued this cycle. Combinational.
- `o_rvalid0` / `o_rvalid1`, out, 1 each: read data valid for the requester. Registered.
- `o_rdata`, out, `DATA_WIDTH`: read data, shared by both requesters.
- `o_bram_addr`, out, `ADDR_WIDTH`: BRAM address.
- `o_bram_write`, out, 1: BRAM write enable.
- `o_bram_data`, out, `DATA_WIDTH`: BRAM write data.
- `i_bram_data`, in, `DATA_WIDTH`: BRAM read data, available 1 cycle after the address.

## Operation
**Request protocol**
- A requester holds `req`, `addr`, `write` and `wdata` stable until it sees `gnt` high.
- The access completes in the grant cycle.
- Dropping `req` before a grant is allowed; nothing is issued for it.

**Grant logic** (per cycle; `i_rst` high forces both grants to 0)
1. A starving requester wins. Starving means `req` is high and its wait counter equals `MAX_WAIT`. If both are starving, the one not in `last` wins.
2. Otherwise, if `lock_owner` is set and `i_req1` is high, requester 1 wins.
3. Otherwise, a single requester wins.
4. Otherwise, with both requesting, the one not equal to `last` wins (round-robin).

**BRAM drive**
- The winner's addr/write/wdata drive the BRAM port combinationally.
- With no grant: `o_bram_write` = 0, `o_bram_addr` = 0, `o_bram_data` = 0.

**State**
- `last` (1 bit) updates to the winner on every grant.
- `lock_owner` is set when requester 1 is granted with `i_lock1` = 1.
- `lock_owner` is cleared when `i_lock1` = 0, or when requester 0 is granted via starvation. After a starvation-forced break, the lock must be re-acquired by a fresh grant.
- Wait counters, one per requester, 4 bits each:
  - increment when `req` is high and `gnt` is low, saturating at `MAX_WAIT`;
  - clear on grant or when `req` is low.

**Read return**
- `o_rvalidN` is high exactly 1 cycle after a granted read by requester N.
- `o_rdata` = `i_bram_data` (pass-through). It is don't-care when no rvalid is high.
- Writes produce no rvalid.

**Reset values**
- `last` = 1, so requester 0 wins the first tie.
- `lock_owner` = 0, counters = 0, both rvalids = 0.
- During reset all grants and `o_bram_write` are 0, and no access is issued.

## Timing
- Grant latency is 0 cycles for an uncontended request. Read data arrives 1 cycle after grant.
- Back-to-back grants to alternating or the same requester are allowed every cycle; throughput is 1 access per cycle.
- With no lock, maximum wait under continuous contention is 1 cycle.
- With a lock held, requester 0 waits at most `MAX_WAIT` cycles, then is granted for one cycle.
- A read granted in cycle N sees every write granted in cycles before N.
- Reset asserted in cycle N: no grant in N. A read granted in N-1 still returns its rvalid in N. Reset clears the rvalid from N+1.

## Test plan
- Reset, then req0 read of addr 5 (BRAM holds 0xA5) -> `o_gnt0` = 1 in the same cycle; next cycle `o_rvalid0` = 1 and `o_rdata` = 0xA5.
- Both requesters hold continuous reads (req0 addr 1, req1 addr 2) for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with 0. Each rvalid follows its grant by one cycle.
- req1 writes 0x3C to addr 7 while req0 reads addr 7 in the same cycle -> tie grants req0 first and it reads the old value. req1's write follows, and a subsequent req0 read returns 0x3C.
- req1 holds `i_lock1` = 1 with continuous writes while req0 requests, `MAX_WAIT` = 4 -> req1 is granted 4 cycles, req0 in cycle 5, then lock is released. req1 then re-acquires only by a fresh grant, so req0 is not starved twice.
- Reset asserted for 1 cycle while both request and a read is in flight -> no grant that cycle, the pending rvalid still pulses, and after reset the first tie goes to req0.
- req0 drops `req` after 1 denied cycle -> no access issued for it and its wait counter returns to 0.
